signal_cfg_shadow: RTL



---
 rtl/signal_cfg_shadow.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/signal_cfg_shadow.sv
// signal_cfg_shadow
// Double-buffered configuration bank for the signal-generator config slice.
// Software writes 32-bit words into a staging copy; a commit copies the whole
// staging copy into the active copy (cfg_data) in a single cycle, either
// immediately or at the next signal-period boundary (sync_pulse), so the
// generator never sees a partially updated set of fields.
//
// State table:
//   state    | meaning
//   ST_IDLE  | accepting writes; commits transfer now or arm
//   ST_ARMED | deferred commit armed, waiting for sync_pulse or abort
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  word write into staging (1 per cycle)
//   wr_ack / wr_err      registered 1-cycle response to a write
//   commit, commit_mode  transfer request; mode 0 = now, 1 = at sync_pulse
//   sync_pulse           period-boundary strobe
//   abort                cancels an armed commit
//   cfg_data             active configuration
//   update_pulse         first cycle a new cfg_data is visible
//   pending              deferred commit armed
//   dirty                staging written since last commit
//   commit_count         completed commits, wrapping 16-bit counter

module signal_cfg_shadow #(
  parameter int CFG_WIDTH  = 832,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  wr_ack,
  output logic                  wr_err,
  input  logic                  commit,
  input  logic                  commit_mode,
  input  logic                  sync_pulse,
  input  logic                  abort,
  output logic [CFG_WIDTH-1:0]  cfg_data,
  output logic                  update_pulse,
  output logic                  pending,
  output logic                  dirty,
  output logic [15:0]           commit_count
);

  localparam int NUM_WORDS = CFG_WIDTH / 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CFG_WIDTH-1:0] staging_q, staging_d;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 wr_err_q, wr_err_d;
  logic                 update_q, update_d;
  logic                 pending_q, pending_d;
  logic                 dirty_q, dirty_d;
  logic [15:0]          count_q, count_d;

  logic addr_ok;
  logic wr_ok;
  logic do_transfer;

  always_comb begin
    addr_ok     = (32'(wr_addr) < 32'(NUM_WORDS));
    // Writes are locked out while armed so the armed snapshot cannot move.
    wr_ok       = wr_en && (state_q == ST_IDLE) && addr_ok;
    wr_ack_d    = wr_ok;
    wr_err_d    = wr_en && !wr_ok;

    // staging_d already carries a same-cycle write, so a commit in that
    // cycle picks it up.
    staging_d = staging_q;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (wr_ok && (wr_addr == ADDR_WIDTH'(k))) begin
        staging_d[32*k +: 32] = wr_data;
      end
    end

    state_d     = state_q;
    do_transfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          if (!commit_mode || sync_pulse) begin
            do_transfer = 1'b1;
          end else begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        // abort wins over a coincident sync_pulse; commit is ignored here
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sync_pulse) begin
          do_transfer = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cfg_d     = do_transfer ? staging_d : cfg_q;
    update_d  = do_transfer;
    count_d   = do_transfer ? count_q + 16'd1 : count_q;
    pending_d = (state_d == ST_ARMED);

    if (do_transfer) begin
      dirty_d = 1'b0;
    end else if (wr_ok) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      staging_q <= '0;
      cfg_q     <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      update_q  <= 1'b0;
      pending_q <= 1'b0;
      dirty_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      staging_q <= staging_d;
      cfg_q     <= cfg_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      update_q  <= update_d;
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
      count_q   <= count_d;
    end
  end

  assign cfg_data     = cfg_q;
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign update_pulse = update_q;
  assign pending      = pending_q;
  assign dirty        = dirty_q;
  assign commit_count = count_q;

endmodule
